gpr_context_sequencer: RTL and testbench

Sequencer that moves integer registers x1..x(NUM_REG-1) between the general-purpose register file and a memory frame on interrupt entry (save) and interrupt return (restore). It sits beside the register file, drives the register file's rs2 read index and its write port, stalls the pipeline while active, and issues single-beat memory requests through a req/ack handshake.

---
 rtl/gpr_context_sequencer_if.sv | 31 +++
 rtl/gpr_context_sequencer.sv | 173 +++++++++++++++++
 tb/tb_gpr_context_sequencer.sv | 366 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/gpr_context_sequencer_if.sv
// Memory-side bus of the GPR context sequencer: single-beat request/acknowledge
// channel that carries register stores on save and loads on restore.
// Signal suffixes are named from the sequencer's point of view.
interface gpr_context_sequencer_if #(
    parameter int SIZE_REG = 64
);
    logic                mem_req_out;
    logic                mem_we_out;
    logic [63:0]         mem_addr_out;
    logic [SIZE_REG-1:0] mem_wdata_out;
    logic                mem_ack_in;
    logic [SIZE_REG-1:0] mem_rdata_in;

    modport master (
        output mem_req_out,
        output mem_we_out,
        output mem_addr_out,
        output mem_wdata_out,
        input  mem_ack_in,
        input  mem_rdata_in
    );

    modport slave (
        input  mem_req_out,
        input  mem_we_out,
        input  mem_addr_out,
        input  mem_wdata_out,
        output mem_ack_in,
        output mem_rdata_in
    );
endinterface

// File: rtl/gpr_context_sequencer.sv
// GPR context sequencer: walks x1..x(NUM_REG-1) and copies them into a memory
// frame on interrupt entry (save) or back into the register file on return
// (restore). Frame slot for register idx lives at base + 8*(idx-1).
// Optional build macro CONTEXT_SKIP_SP_EN: when defined, x2 (stack pointer) is
// skipped on both paths while its frame slot stays reserved.
module gpr_context_sequencer #(
    parameter int NUM_REG  = 32,
    parameter int SIZE_REG = 64
) (
    input  logic                     clk_in,
    input  logic                     rst_in,
    input  logic                     save_req_in,
    input  logic                     restore_req_in,
    input  logic [63:0]              base_addr_in,
    output logic                     busy_out,
    output logic                     stall_signal_out,
    output logic                     done_out,
    output logic [4:0]               gpr_rs_out,
    input  logic [SIZE_REG-1:0]      gpr_rdata_in,
    output logic [4:0]               gpr_rd_out,
    output logic [SIZE_REG-1:0]      gpr_wr_data_out,
    output logic                     gpr_wr_en_out,
    gpr_context_sequencer_if.master  mem_bus
);

    typedef enum logic [2:0] {
        IDLE,
        SAVE_RD,
        SAVE_LATCH,
        SAVE_MEM,
        RESTORE_MEM,
        RESTORE_WR,
        DONE
    } state_t;

    localparam logic [4:0] FIRST_IDX = 5'd1;
    localparam logic [4:0] LAST_IDX  = 5'(NUM_REG - 1);

    state_t              state_q,    state_d;
    logic [4:0]          idx_q,      idx_d;
    logic [63:0]         base_q,     base_d;
    logic [SIZE_REG-1:0] data_q,     data_d;
    logic                mem_req_q,  mem_req_d;
    logic                mem_we_q,   mem_we_d;
    logic [63:0]         mem_addr_q, mem_addr_d;

    // Index of the register that follows idx in the transfer order.
    function automatic logic [4:0] next_idx(input logic [4:0] idx);
`ifdef CONTEXT_SKIP_SP_EN
        next_idx = (idx == 5'd1) ? 5'd3 : idx + 5'd1;
`else
        next_idx = idx + 5'd1;
`endif
    endfunction

    // Frame slot address for a register; wraps modulo 2^64.
    function automatic logic [63:0] slot_addr(input logic [63:0] base, input logic [4:0] idx);
        logic [4:0] slot;
        slot      = idx - 5'd1;
        slot_addr = base + {56'd0, slot, 3'b000};
    endfunction

    // Next-state logic: sequencing plus the registered memory-bus and data values.
    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        base_d     = base_q;
        data_d     = data_q;
        mem_req_d  = mem_req_q;
        mem_we_d   = mem_we_q;
        mem_addr_d = mem_addr_q;
        case (state_q)
            IDLE: begin
                if (save_req_in) begin
                    state_d = SAVE_RD;
                    idx_d   = FIRST_IDX;
                    base_d  = base_addr_in;
                end else if (restore_req_in) begin
                    state_d    = RESTORE_MEM;
                    idx_d      = FIRST_IDX;
                    base_d     = base_addr_in;
                    mem_req_d  = 1'b1;
                    mem_we_d   = 1'b0;
                    mem_addr_d = slot_addr(base_addr_in, FIRST_IDX);
                end
            end
            SAVE_RD: begin
                state_d = SAVE_LATCH;
            end
            SAVE_LATCH: begin
                data_d     = gpr_rdata_in;
                mem_req_d  = 1'b1;
                mem_we_d   = 1'b1;
                mem_addr_d = slot_addr(base_q, idx_q);
                state_d    = SAVE_MEM;
            end
            SAVE_MEM: begin
                if (mem_bus.mem_ack_in) begin
                    mem_req_d = 1'b0;
                    mem_we_d  = 1'b0;
                    if (idx_q == LAST_IDX) begin
                        state_d = DONE;
                    end else begin
                        idx_d   = next_idx(idx_q);
                        state_d = SAVE_RD;
                    end
                end
            end
            RESTORE_MEM: begin
                if (mem_bus.mem_ack_in) begin
                    data_d    = mem_bus.mem_rdata_in;
                    mem_req_d = 1'b0;
                    state_d   = RESTORE_WR;
                end
            end
            RESTORE_WR: begin
                if (idx_q == LAST_IDX) begin
                    state_d = DONE;
                end else begin
                    idx_d      = next_idx(idx_q);
                    mem_req_d  = 1'b1;
                    mem_we_d   = 1'b0;
                    mem_addr_d = slot_addr(base_q, next_idx(idx_q));
                    state_d    = RESTORE_MEM;
                end
            end
            DONE: begin
                idx_d   = FIRST_IDX;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q    <= IDLE;
            idx_q      <= FIRST_IDX;
            base_q     <= '0;
            data_q     <= '0;
            mem_req_q  <= 1'b0;
            mem_we_q   <= 1'b0;
            mem_addr_q <= '0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            base_q     <= base_d;
            data_q     <= data_d;
            mem_req_q  <= mem_req_d;
            mem_we_q   <= mem_we_d;
            mem_addr_q <= mem_addr_d;
        end
    end

    // Status and register-file ports decoded from the current state.
    assign busy_out         = (state_q != IDLE);
    assign stall_signal_out = busy_out;
    assign done_out         = (state_q == DONE);
    assign gpr_rs_out       = (state_q == SAVE_RD || state_q == SAVE_LATCH) ? idx_q : 5'd0;
    assign gpr_wr_en_out    = (state_q == RESTORE_WR);
    assign gpr_rd_out       = gpr_wr_en_out ? idx_q : 5'd0;
    assign gpr_wr_data_out  = gpr_wr_en_out ? data_q : '0;

    // Memory bus driven straight from registers so it stays stable while waiting.
    assign mem_bus.mem_req_out   = mem_req_q;
    assign mem_bus.mem_we_out    = mem_we_q;
    assign mem_bus.mem_addr_out  = mem_addr_q;
    assign mem_bus.mem_wdata_out = data_q;

endmodule

// File: tb/tb_gpr_context_sequencer.sv
// Self-checking bench for gpr_context_sequencer. Models the register file and
// the memory frame, records every bus transaction, and compares the recorded
// traffic with the frame expected from the save/restore rules.
// Honours CONTEXT_SKIP_SP_EN when compiled with it.
module tb_gpr_context_sequencer;
    localparam int NUM_REG  = 32;
    localparam int SIZE_REG = 64;
`ifdef CONTEXT_SKIP_SP_EN
    localparam bit SKIP_SP = 1'b1;
`else
    localparam bit SKIP_SP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        save_req;
    logic        restore_req;
    logic [63:0] base_addr;
    logic        busy;
    logic        stall;
    logic        done;
    logic [4:0]  gpr_rs;
    logic [63:0] gpr_rdata;
    logic [4:0]  gpr_rd;
    logic [63:0] gpr_wr_data;
    logic        gpr_wr_en;

    gpr_context_sequencer_if #(.SIZE_REG(SIZE_REG)) mem_if ();

    gpr_context_sequencer #(
        .NUM_REG (NUM_REG),
        .SIZE_REG(SIZE_REG)
    ) dut (
        .clk_in          (clk),
        .rst_in          (rst),
        .save_req_in     (save_req),
        .restore_req_in  (restore_req),
        .base_addr_in    (base_addr),
        .busy_out        (busy),
        .stall_signal_out(stall),
        .done_out        (done),
        .gpr_rs_out      (gpr_rs),
        .gpr_rdata_in    (gpr_rdata),
        .gpr_rd_out      (gpr_rd),
        .gpr_wr_data_out (gpr_wr_data),
        .gpr_wr_en_out   (gpr_wr_en),
        .mem_bus         (mem_if)
    );

    always #5 clk = ~clk;

    logic [63:0] regs       [NUM_REG];
    logic [63:0] load_words [32];
    logic [63:0] frame_base;
    logic [63:0] slot_off;
    logic [63:0] mem_rdata_val;
    logic        ack_force;
    int          ack_delay;
    int          wait_cnt = 0;
    int          cyc_num  = 0;

    logic [63:0] st_addr_q [$];
    logic [63:0] st_data_q [$];
    logic [63:0] ld_addr_q [$];
    logic [4:0]  wr_idx_q  [$];
    logic [63:0] wr_data_q [$];
    int          done_q    [$];
    int          stab_err  = 0;
    logic        prev_req  = 1'b0;
    logic        prev_ack  = 1'b0;
    logic        prev_we   = 1'b0;
    logic [63:0] prev_addr = '0;
    logic [63:0] prev_wdata = '0;

    int assert_count = 0;
    int fail_count   = 0;
    int req_cycle    = 0;
    int st0, ld0, wr0, dn0, sb0;

    // Memory acknowledges either always (tied high) or after ack_delay wait cycles.
    assign mem_if.mem_ack_in   = ack_force || (mem_if.mem_req_out && (wait_cnt == ack_delay));
    assign mem_if.mem_rdata_in = mem_rdata_val;

    // Load data comes from the preloaded frame relative to frame_base.
    always_comb begin
        slot_off = mem_if.mem_addr_out - frame_base;
        if (slot_off < 64'd256 && slot_off[2:0] == 3'b000) begin
            mem_rdata_val = load_words[slot_off[7:3]];
        end else begin
            mem_rdata_val = 64'hBAD0_BAD0_BAD0_BAD0;
        end
    end

    // Cycle counter, ack wait counter and registered register-file read port.
    always @(posedge clk) begin
        cyc_num <= cyc_num + 1;
        if (mem_if.mem_req_out && !mem_if.mem_ack_in) begin
            wait_cnt <= wait_cnt + 1;
        end else begin
            wait_cnt <= 0;
        end
        gpr_rdata <= regs[gpr_rs];
    end

    // Transaction recorder and bus-stability watcher, sampled mid-cycle.
    always @(negedge clk) begin
        if (!rst) begin
            if (prev_req && !prev_ack &&
                (!mem_if.mem_req_out || mem_if.mem_addr_out != prev_addr ||
                 mem_if.mem_we_out != prev_we ||
                 (prev_we && mem_if.mem_wdata_out != prev_wdata))) begin
                stab_err <= stab_err + 1;
            end
            if (mem_if.mem_req_out && mem_if.mem_ack_in) begin
                if (mem_if.mem_we_out) begin
                    st_addr_q.push_back(mem_if.mem_addr_out);
                    st_data_q.push_back(mem_if.mem_wdata_out);
                end else begin
                    ld_addr_q.push_back(mem_if.mem_addr_out);
                end
            end
            if (gpr_wr_en) begin
                wr_idx_q.push_back(gpr_rd);
                wr_data_q.push_back(gpr_wr_data);
            end
            if (done) begin
                done_q.push_back(cyc_num);
            end
        end
        prev_req   <= mem_if.mem_req_out && !rst;
        prev_ack   <= mem_if.mem_ack_in;
        prev_we    <= mem_if.mem_we_out;
        prev_addr  <= mem_if.mem_addr_out;
        prev_wdata <= mem_if.mem_wdata_out;
    end

    function automatic bit is_transferred(input int i);
        return (i >= 1) && (i <= NUM_REG - 1) && !(SKIP_SP && i == 2);
    endfunction

    function automatic int transfer_count();
        int n = 0;
        for (int i = 0; i < NUM_REG; i++) begin
            if (is_transferred(i)) n++;
        end
        return n;
    endfunction

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        assert_count++;
        assert (observed === expected) else begin
            fail_count++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    task automatic takeSnapshot();
        st0 = st_addr_q.size();
        ld0 = ld_addr_q.size();
        wr0 = wr_idx_q.size();
        dn0 = done_q.size();
        sb0 = stab_err;
    endtask

    // Issue a one-cycle request from a negedge and confirm busy/stall in cycle 1.
    task automatic applyStimulus(input logic s, input logic r, input logic [63:0] b);
        save_req    = s;
        restore_req = r;
        base_addr   = b;
        req_cycle   = cyc_num;
        @(posedge clk);
        #1;
        save_req    = 1'b0;
        restore_req = 1'b0;
        base_addr   = {$urandom, $urandom};
        @(negedge clk);
        checkOutput("start_busy", 64'(busy), 64'd1);
        checkOutput("start_stall", 64'(stall), 64'd1);
    endtask

    task automatic waitForIdle(input string tag, input int expected_idle);
        int n = 0;
        while (busy && n < 3000) begin
            @(negedge clk);
            n++;
        end
        checkOutput({tag, "_finished"}, 64'(busy), 64'd0);
        checkOutput({tag, "_idle_cycle"}, 64'(cyc_num), 64'(expected_idle));
    endtask

    task automatic checkResetState(input string tag);
        checkOutput({tag, "_busy"}, 64'(busy), 64'd0);
        checkOutput({tag, "_stall"}, 64'(stall), 64'd0);
        checkOutput({tag, "_done"}, 64'(done), 64'd0);
        checkOutput({tag, "_rs"}, 64'(gpr_rs), 64'd0);
        checkOutput({tag, "_rd"}, 64'(gpr_rd), 64'd0);
        checkOutput({tag, "_wr_data"}, gpr_wr_data, 64'd0);
        checkOutput({tag, "_wr_en"}, 64'(gpr_wr_en), 64'd0);
        checkOutput({tag, "_mem_req"}, 64'(mem_if.mem_req_out), 64'd0);
        checkOutput({tag, "_mem_we"}, 64'(mem_if.mem_we_out), 64'd0);
        checkOutput({tag, "_mem_addr"}, mem_if.mem_addr_out, 64'd0);
        checkOutput({tag, "_mem_wdata"}, mem_if.mem_wdata_out, 64'd0);
    endtask

    task automatic checkSaveFrame(input logic [63:0] base, input int delay);
        int n, j, slot1;
        n = transfer_count();
        checkOutput("save_store_count", 64'(st_addr_q.size() - st0), 64'(n));
        j = st0;
        for (int i = 1; i < NUM_REG; i++) begin
            if (is_transferred(i)) begin
                if (j < st_addr_q.size()) begin
                    checkOutput("save_addr", st_addr_q[j], base + 64'(8 * (i - 1)));
                    checkOutput("save_data", st_data_q[j], regs[i]);
                end
                j++;
            end
        end
        slot1 = 0;
        for (int k = st0; k < st_addr_q.size(); k++) begin
            if (st_addr_q[k] == base + 64'd8) slot1++;
        end
        checkOutput("save_slot1_access", 64'(slot1), SKIP_SP ? 64'd0 : 64'd1);
        checkOutput("save_no_load", 64'(ld_addr_q.size() - ld0), 64'd0);
        checkOutput("save_no_write", 64'(wr_idx_q.size() - wr0), 64'd0);
        checkOutput("save_stable_wait", 64'(stab_err - sb0), 64'd0);
        checkOutput("save_done_pulses", 64'(done_q.size() - dn0), 64'd1);
        if (done_q.size() > dn0) begin
            checkOutput("save_done_cycle", 64'(done_q[dn0]), 64'(req_cycle + 3 * n + 1 + n * delay));
        end
    endtask

    task automatic checkRestoreFrame(input logic [63:0] base, input int delay);
        int n, j, slot1, x0_cnt, x2_cnt;
        n = transfer_count();
        checkOutput("restore_load_count", 64'(ld_addr_q.size() - ld0), 64'(n));
        checkOutput("restore_write_count", 64'(wr_idx_q.size() - wr0), 64'(n));
        j = 0;
        for (int k = 1; k < NUM_REG; k++) begin
            if (is_transferred(k)) begin
                if (ld0 + j < ld_addr_q.size()) begin
                    checkOutput("restore_addr", ld_addr_q[ld0 + j], base + 64'(8 * (k - 1)));
                end
                if (wr0 + j < wr_idx_q.size()) begin
                    checkOutput("restore_rd", 64'(wr_idx_q[wr0 + j]), 64'(k));
                    checkOutput("restore_data", wr_data_q[wr0 + j], load_words[k - 1]);
                end
                j++;
            end
        end
        slot1  = 0;
        x0_cnt = 0;
        x2_cnt = 0;
        for (int k = ld0; k < ld_addr_q.size(); k++) begin
            if (ld_addr_q[k] == base + 64'd8) slot1++;
        end
        for (int k = wr0; k < wr_idx_q.size(); k++) begin
            if (wr_idx_q[k] == 5'd0) x0_cnt++;
            if (wr_idx_q[k] == 5'd2) x2_cnt++;
        end
        checkOutput("restore_slot1_access", 64'(slot1), SKIP_SP ? 64'd0 : 64'd1);
        checkOutput("restore_x0_writes", 64'(x0_cnt), 64'd0);
        checkOutput("restore_x2_writes", 64'(x2_cnt), SKIP_SP ? 64'd0 : 64'd1);
        checkOutput("restore_no_store", 64'(st_addr_q.size() - st0), 64'd0);
        checkOutput("restore_stable_wait", 64'(stab_err - sb0), 64'd0);
        checkOutput("restore_done_pulses", 64'(done_q.size() - dn0), 64'd1);
        if (done_q.size() > dn0) begin
            checkOutput("restore_done_cycle", 64'(done_q[dn0]), 64'(req_cycle + 2 * n + 1 + n * delay));
        end
    endtask

    // Directed sequence of scenarios with randomized data, bases and ack delays.
    initial begin
        int n;
        logic [63:0] b;
        n           = transfer_count();
        rst         = 1'b1;
        save_req    = 1'b0;
        restore_req = 1'b0;
        base_addr   = '0;
        ack_force   = 1'b1;
        ack_delay   = 0;
        frame_base  = '0;
        for (int i = 0; i < NUM_REG; i++) regs[i] = '0;
        for (int i = 0; i < 32; i++) load_words[i] = '0;

        repeat (3) @(negedge clk);
        checkResetState("reset");
        rst = 1'b0;
        @(negedge clk);

        $display("[TB] save of all registers, ack tied high");
        for (int i = 0; i < NUM_REG; i++) regs[i] = 64'h1000 + 64'(i);
        takeSnapshot();
        applyStimulus(1'b1, 1'b0, 64'h0000_0000_87FF_FF00);
        waitForIdle("save_all", req_cycle + 3 * n + 2);
        checkSaveFrame(64'h0000_0000_87FF_FF00, 0);

        $display("[TB] restore issued in the first idle cycle");
        for (int k = 0; k < 32; k++) load_words[k] = 64'hA000 + 64'(k);
        frame_base = {$urandom, $urandom} & ~64'h7;
        takeSnapshot();
        applyStimulus(1'b0, 1'b1, frame_base);
        waitForIdle("restore", req_cycle + 2 * n + 2);
        checkRestoreFrame(frame_base, 0);

        $display("[TB] save with three ack wait cycles per request");
        ack_force = 1'b0;
        ack_delay = 3;
        for (int i = 0; i < NUM_REG; i++) regs[i] = {$urandom, $urandom};
        b = {$urandom, $urandom} & ~64'h7;
        takeSnapshot();
        applyStimulus(1'b1, 1'b0, b);
        waitForIdle("save_bp", req_cycle + 3 * n + 2 + 3 * n);
        checkSaveFrame(b, 3);

        $display("[TB] restore with random ack delay");
        ack_delay = int'($urandom_range(1, 3));
        for (int k = 0; k < 32; k++) load_words[k] = {$urandom, $urandom};
        frame_base = {$urandom, $urandom} & ~64'h7;
        takeSnapshot();
        applyStimulus(1'b0, 1'b1, frame_base);
        waitForIdle("restore_bp", req_cycle + 2 * n + 2 + ack_delay * n);
        checkRestoreFrame(frame_base, ack_delay);

        $display("[TB] simultaneous requests, restore pulse while saving");
        ack_delay = 0;
        for (int i = 0; i < NUM_REG; i++) regs[i] = {$urandom, $urandom};
        b = {$urandom, $urandom} & ~64'h7;
        takeSnapshot();
        applyStimulus(1'b1, 1'b1, b);
        repeat (9) @(negedge clk);
        restore_req = 1'b1;
        @(posedge clk);
        #1;
        restore_req = 1'b0;
        waitForIdle("both_req", req_cycle + 3 * n + 2);
        checkSaveFrame(b, 0);
        repeat (3) @(negedge clk);
        checkOutput("no_queued_restore_busy", 64'(busy), 64'd0);
        checkOutput("no_queued_restore_loads", 64'(ld_addr_q.size() - ld0), 64'd0);

        $display("[TB] reset in cycle 40 of a save, then fresh save");
        for (int i = 0; i < NUM_REG; i++) regs[i] = {$urandom, $urandom};
        b = {$urandom, $urandom} & ~64'h7;
        takeSnapshot();
        applyStimulus(1'b1, 1'b0, b);
        repeat (39) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        checkResetState("mid_reset");
        rst = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("mid_reset_no_done", 64'(done_q.size() - dn0), 64'd0);
        checkOutput("mid_reset_idle", 64'(busy), 64'd0);
        b = {$urandom, $urandom} & ~64'h7;
        takeSnapshot();
        applyStimulus(1'b1, 1'b0, b);
        waitForIdle("fresh_save", req_cycle + 3 * n + 2);
        checkSaveFrame(b, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
        $finish;
    end

endmodule
